// File: rtl/rv_alu2_if.sv
// ============================================================================
// Module      : rv_alu2_if
// Description : Bundle of the execute-stage data path signals. The master side
//               is the operand-select stage plus the control that flushes or
//               stalls execute; the slave side is the execute stage itself.
//               i_*  : operands, decoded control and PC values into execute
//               o_*  : registered control, ALU result and the fetch redirect
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rv_alu2_if #(
   parameter int IADDR_SPACE_BITS = 32
);
   logic                          i_flush;
   logic                          i_stall;
   logic [31:0]                   i_op1;
   logic [31:0]                   i_op2;
   logic [3:0]                    i_alu_op;
   logic [2:0]                    i_funct3;
   logic                          i_reg_write;
   logic [4:0]                    i_rd;
   logic                          i_store;
   logic                          i_inst_jal_jalr;
   logic                          i_inst_branch;
   logic [1:0]                    i_res_src;
   logic [IADDR_SPACE_BITS-1:1]   i_pc_next;
   logic [IADDR_SPACE_BITS-1:1]   i_pc_target;
   logic [31:0]                   i_reg_data2;

   logic [31:0]                   o_result;
   logic                          o_reg_write;
   logic [4:0]                    o_rd;
   logic                          o_store;
   logic [31:0]                   o_store_data;
   logic [2:0]                    o_funct3;
   logic [1:0]                    o_res_src;
   logic [IADDR_SPACE_BITS-1:1]   o_pc_next;
   logic                          o_pc_select;
   logic [IADDR_SPACE_BITS-1:1]   o_pc_target;
   logic                          o_busy;

   modport master (
      output i_flush, i_stall, i_op1, i_op2, i_alu_op, i_funct3, i_reg_write,
             i_rd, i_store, i_inst_jal_jalr, i_inst_branch, i_res_src,
             i_pc_next, i_pc_target, i_reg_data2,
      input  o_result, o_reg_write, o_rd, o_store, o_store_data, o_funct3,
             o_res_src, o_pc_next, o_pc_select, o_pc_target, o_busy
   );

   modport slave (
      input  i_flush, i_stall, i_op1, i_op2, i_alu_op, i_funct3, i_reg_write,
             i_rd, i_store, i_inst_jal_jalr, i_inst_branch, i_res_src,
             i_pc_next, i_pc_target, i_reg_data2,
      output o_result, o_reg_write, o_rd, o_store, o_store_data, o_funct3,
             o_res_src, o_pc_next, o_pc_select, o_pc_target, o_busy
   );
endinterface

`default_nettype wire

// File: rtl/rv_alu2.sv
// ============================================================================
// Module      : rv_alu2
// Description : RISC-V execute stage. Registers the operand-select outputs,
//               computes the integer ALU result combinationally from the
//               stage register, resolves branches/jumps into a fetch redirect
//               and forwards store/writeback control downstream.
//               Optional iterative restoring divider (DIV/DIVU/REM/REMU)
//               enabled by the macro RV_EXT_M_EN; it holds the stage through
//               o_busy while iterating.
// Ports       : i_clk    - clock, all state on the rising edge
//               i_reset  - synchronous active-high reset
//               bus      - rv_alu2_if slave: operands/control in, result,
//                          registered control and redirect out
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_alu2 #(
   parameter int IADDR_SPACE_BITS = 32
) (
   input  logic      i_clk,
   input  logic      i_reset,
   rv_alu2_if.slave  bus
);

   localparam logic [3:0] c_op_add  = 4'd0;
   localparam logic [3:0] c_op_sub  = 4'd1;
   localparam logic [3:0] c_op_sll  = 4'd2;
   localparam logic [3:0] c_op_slt  = 4'd3;
   localparam logic [3:0] c_op_sltu = 4'd4;
   localparam logic [3:0] c_op_xor  = 4'd5;
   localparam logic [3:0] c_op_srl  = 4'd6;
   localparam logic [3:0] c_op_sra  = 4'd7;
   localparam logic [3:0] c_op_or   = 4'd8;
   localparam logic [3:0] c_op_and  = 4'd9;
   localparam logic [3:0] c_op_pass = 4'd10;
`ifdef RV_EXT_M_EN
   localparam logic [3:0] c_op_div  = 4'd11;
   localparam logic [3:0] c_op_divu = 4'd12;
   localparam logic [3:0] c_op_rem  = 4'd13;
   localparam logic [3:0] c_op_remu = 4'd14;
`endif

   // ------------------------------------------------------------------------
   // Stage register
   // ------------------------------------------------------------------------
   logic [31:0]                 r_op1;
   logic [31:0]                 r_op2;
   logic [3:0]                  r_alu_op;
   logic [2:0]                  r_funct3;
   logic                        r_reg_write;
   logic [4:0]                  r_rd;
   logic                        r_store;
   logic                        r_jal_jalr;
   logic                        r_branch;
   logic [1:0]                  r_res_src;
   logic [IADDR_SPACE_BITS-1:1] r_pc_next;
   logic [IADDR_SPACE_BITS-1:1] r_pc_target;
   logic [31:0]                 r_store_data;

   logic w_busy;
   logic w_load;

   assign w_load = !bus.i_stall && !w_busy;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_op1        <= '0;
         r_op2        <= '0;
         r_alu_op     <= c_op_add;
         r_funct3     <= '0;
         r_reg_write  <= 1'b0;
         r_rd         <= '0;
         r_store      <= 1'b0;
         r_jal_jalr   <= 1'b0;
         r_branch     <= 1'b0;
         r_res_src    <= '0;
         r_pc_next    <= '0;
         r_pc_target  <= '0;
         r_store_data <= '0;
      end else if (bus.i_flush) begin
         // Only the fields with side effects are cleared; the rest are don't-care.
         r_reg_write <= 1'b0;
         r_store     <= 1'b0;
         r_jal_jalr  <= 1'b0;
         r_branch    <= 1'b0;
         r_res_src   <= '0;
         r_alu_op    <= c_op_add;
      end else if (w_load) begin
         r_op1        <= bus.i_op1;
         r_op2        <= bus.i_op2;
         r_alu_op     <= bus.i_alu_op;
         r_funct3     <= bus.i_funct3;
         r_reg_write  <= bus.i_reg_write;
         r_rd         <= bus.i_rd;
         r_store      <= bus.i_store;
         r_jal_jalr   <= bus.i_inst_jal_jalr;
         r_branch     <= bus.i_inst_branch;
         r_res_src    <= bus.i_res_src;
         r_pc_next    <= bus.i_pc_next;
         r_pc_target  <= bus.i_pc_target;
         r_store_data <= bus.i_reg_data2;
      end
   end

   // ------------------------------------------------------------------------
   // Optional iterative divider
   // ------------------------------------------------------------------------
`ifdef RV_EXT_M_EN
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } div_state_t;

   div_state_t  r_state, w_state_next;
   logic [4:0]  r_count, w_count_next;
   logic [31:0] r_quo, w_quo_next;
   logic [31:0] r_rem, w_rem_next;
   logic [31:0] r_den, w_den_next;
   logic [31:0] r_div_result, w_div_result_next;

   logic        w_held_div, w_held_signed, w_held_rem;
   logic        w_in_div, w_in_signed, w_in_rem;
   logic        w_in_dz, w_in_ovf;
   logic [31:0] w_in_mag1, w_in_mag2, w_in_special;
   logic [32:0] w_rem_shift, w_rem_diff;
   logic        w_ge;
   logic [31:0] w_quo_step, w_rem_step, w_q_final, w_r_final;

   assign w_held_div    = (r_alu_op >= c_op_div) && (r_alu_op <= c_op_remu);
   assign w_held_signed = (r_alu_op == c_op_div) || (r_alu_op == c_op_rem);
   assign w_held_rem    = (r_alu_op == c_op_rem) || (r_alu_op == c_op_remu);

   assign w_in_div    = (bus.i_alu_op >= c_op_div) && (bus.i_alu_op <= c_op_remu);
   assign w_in_signed = (bus.i_alu_op == c_op_div) || (bus.i_alu_op == c_op_rem);
   assign w_in_rem    = (bus.i_alu_op == c_op_rem) || (bus.i_alu_op == c_op_remu);
   assign w_in_dz     = (bus.i_op2 == 32'd0);
   assign w_in_ovf    = w_in_signed && (bus.i_op1 == 32'h8000_0000) &&
                        (bus.i_op2 == 32'hFFFF_FFFF);

   // Results that need no iteration: x/0 and the one signed overflow case.
   assign w_in_special = w_in_dz ? (w_in_rem ? bus.i_op1 : 32'hFFFF_FFFF)
                                 : (w_in_rem ? 32'd0     : 32'h8000_0000);

   // The loop works on magnitudes; 0x80000000 is its own magnitude as unsigned.
   assign w_in_mag1 = (w_in_signed && bus.i_op1[31]) ? -bus.i_op1 : bus.i_op1;
   assign w_in_mag2 = (w_in_signed && bus.i_op2[31]) ? -bus.i_op2 : bus.i_op2;

   // One restoring step. The remainder is always below the divisor, so the
   // borrow out of the 33-bit subtraction alone decides the quotient bit.
   assign w_rem_shift = {r_rem, r_quo[31]};
   assign w_rem_diff  = w_rem_shift - {1'b0, r_den};
   assign w_ge        = !w_rem_diff[32];
   assign w_rem_step  = w_ge ? w_rem_diff[31:0] : w_rem_shift[31:0];
   assign w_quo_step  = {r_quo[30:0], w_ge};

   assign w_q_final = (w_held_signed && (r_op1[31] ^ r_op2[31])) ? -w_quo_step : w_quo_step;
   assign w_r_final = (w_held_signed && r_op1[31]) ? -w_rem_step : w_rem_step;

   assign w_busy = w_held_div && (r_state != S_DONE);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= S_IDLE;
         r_count      <= '0;
         r_quo        <= '0;
         r_rem        <= '0;
         r_den        <= '0;
         r_div_result <= '0;
      end else if (bus.i_flush) begin
         r_state <= S_IDLE;
      end else begin
         r_state      <= w_state_next;
         r_count      <= w_count_next;
         r_quo        <= w_quo_next;
         r_rem        <= w_rem_next;
         r_den        <= w_den_next;
         r_div_result <= w_div_result_next;
      end
   end

   always_comb begin
      w_state_next      = r_state;
      w_count_next      = r_count;
      w_quo_next        = r_quo;
      w_rem_next        = r_rem;
      w_den_next        = r_den;
      w_div_result_next = r_div_result;
      case (r_state)
         S_RUN: begin
            w_quo_next   = w_quo_step;
            w_rem_next   = w_rem_step;
            w_count_next = r_count - 5'd1;
            if (r_count == 5'd0) begin
               w_state_next      = S_DONE;
               w_div_result_next = w_held_rem ? w_r_final : w_q_final;
            end
         end
         default: begin
            // IDLE and DONE both follow whatever the stage register loads next.
            if (w_load) begin
               if (!w_in_div) begin
                  w_state_next = S_IDLE;
               end else if (w_in_dz || w_in_ovf) begin
                  w_state_next      = S_DONE;
                  w_div_result_next = w_in_special;
               end else begin
                  w_state_next = S_RUN;
                  w_count_next = 5'd31;
                  w_quo_next   = w_in_mag1;
                  w_rem_next   = '0;
                  w_den_next   = w_in_mag2;
               end
            end
         end
      endcase
   end
`else
   assign w_busy = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // ALU and branch resolution
   // ------------------------------------------------------------------------
   logic [4:0]         w_shamt;
   logic signed [31:0] w_sra;
   logic [31:0]        w_result;
   logic               w_cond;

   assign w_shamt = r_op2[4:0];
   assign w_sra   = $signed(r_op1) >>> w_shamt;

   always_comb begin
      w_result = '0;
      case (r_alu_op)
         c_op_add:  w_result = r_op1 + r_op2;
         c_op_sub:  w_result = r_op1 - r_op2;
         c_op_sll:  w_result = r_op1 << w_shamt;
         c_op_slt:  w_result = {31'd0, $signed(r_op1) < $signed(r_op2)};
         c_op_sltu: w_result = {31'd0, r_op1 < r_op2};
         c_op_xor:  w_result = r_op1 ^ r_op2;
         c_op_srl:  w_result = r_op1 >> w_shamt;
         c_op_sra:  w_result = w_sra;
         c_op_or:   w_result = r_op1 | r_op2;
         c_op_and:  w_result = r_op1 & r_op2;
         c_op_pass: w_result = r_op2;
`ifdef RV_EXT_M_EN
         c_op_div, c_op_divu, c_op_rem, c_op_remu: w_result = r_div_result;
`endif
         default:   w_result = '0;
      endcase
   end

   always_comb begin
      w_cond = 1'b0;
      case (r_funct3)
         3'b000:  w_cond = (r_op1 == r_op2);
         3'b001:  w_cond = (r_op1 != r_op2);
         3'b100:  w_cond = ($signed(r_op1) <  $signed(r_op2));
         3'b101:  w_cond = ($signed(r_op1) >= $signed(r_op2));
         3'b110:  w_cond = (r_op1 <  r_op2);
         3'b111:  w_cond = (r_op1 >= r_op2);
         default: w_cond = 1'b0;
      endcase
   end

   assign bus.o_result     = w_result;
   assign bus.o_reg_write  = r_reg_write;
   assign bus.o_rd         = r_rd;
   assign bus.o_store      = r_store;
   assign bus.o_store_data = r_store_data;
   assign bus.o_funct3     = r_funct3;
   assign bus.o_res_src    = r_res_src;
   assign bus.o_pc_next    = r_pc_next;
   assign bus.o_pc_select  = r_jal_jalr | (r_branch & w_cond);
   assign bus.o_pc_target  = r_pc_target;
   assign bus.o_busy       = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_rv_alu2.sv
// ============================================================================
// Module      : tb_rv_alu2
// Description : Self-checking bench for rv_alu2. A reference model tracks the
//               stage contents and divide latency from the architectural
//               rules; every negative clock edge the DUT outputs are compared
//               against it, and directed vectors add literal expectations.
//               Works with or without RV_EXT_M_EN defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv_alu2;

   localparam int AW = 32;
`ifdef RV_EXT_M_EN
   localparam bit M_EN = 1'b1;
`else
   localparam bit M_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rv_alu2_if #(.IADDR_SPACE_BITS(AW)) bus ();

   rv_alu2 #(.IADDR_SPACE_BITS(AW)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   int n_assert = 0;
   int n_fail   = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   // ------------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------------
   function automatic bit is_div(input logic [3:0] op);
      return (op >= 4'd11) && (op <= 4'd14);
   endfunction

   function automatic bit no_iter(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      return (b == 32'd0) ||
             (((op == 4'd11) || (op == 4'd13)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
   endfunction

   function automatic logic [31:0] model_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] sa, sb;
      int unsigned sh;
      sa = a;
      sb = b;
      sh = b % 32;
      case (op)
         4'd0:  return a + b;
         4'd1:  return a - b;
         4'd2:  return a << sh;
         4'd3:  return (sa < sb) ? 32'd1 : 32'd0;
         4'd4:  return (a < b) ? 32'd1 : 32'd0;
         4'd5:  return a ^ b;
         4'd6:  return a >> sh;
         4'd7:  return sa >>> sh;
         4'd8:  return a | b;
         4'd9:  return a & b;
         4'd10: return b;
         4'd11, 4'd12, 4'd13, 4'd14: begin
            if (!M_EN) return 32'd0;
            if (b == 32'd0) return ((op == 4'd13) || (op == 4'd14)) ? a : 32'hFFFF_FFFF;
            if (no_iter(op, a, b)) return (op == 4'd13) ? 32'd0 : 32'h8000_0000;
            case (op)
               4'd11:   return sa / sb;
               4'd12:   return a / b;
               4'd13:   return sa % sb;
               default: return a % b;
            endcase
         end
         default: return 32'd0;
      endcase
   endfunction

   function automatic bit model_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] sa, sb;
      sa = a;
      sb = b;
      case (f3)
         3'b000:  return a == b;
         3'b001:  return a != b;
         3'b100:  return sa < sb;
         3'b101:  return sa >= sb;
         3'b110:  return a < b;
         3'b111:  return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   bit              m_live = 1'b0;
   logic [31:0]     m_op1, m_op2, m_sd;
   logic [3:0]      m_aluop;
   logic [2:0]      m_f3;
   logic            m_rw, m_store, m_jj, m_br;
   logic [4:0]      m_rd;
   logic [1:0]      m_rs;
   logic [AW-1:1]   m_pcn, m_pct;
   int              m_cnt = 0;   // cycles of busy still to come

   always @(posedge clk) begin
      if (rst) begin
         m_live = 1'b1;
         m_op1 = '0; m_op2 = '0; m_sd = '0; m_aluop = '0; m_f3 = '0;
         m_rw = 1'b0; m_store = 1'b0; m_jj = 1'b0; m_br = 1'b0;
         m_rd = '0; m_rs = '0; m_pcn = '0; m_pct = '0; m_cnt = 0;
      end else if (bus.i_flush) begin
         m_rw = 1'b0; m_store = 1'b0; m_jj = 1'b0; m_br = 1'b0;
         m_rs = '0; m_aluop = '0; m_cnt = 0;
      end else if (!bus.i_stall && m_cnt == 0) begin
         m_op1 = bus.i_op1; m_op2 = bus.i_op2; m_sd = bus.i_reg_data2;
         m_aluop = bus.i_alu_op; m_f3 = bus.i_funct3;
         m_rw = bus.i_reg_write; m_store = bus.i_store;
         m_jj = bus.i_inst_jal_jalr; m_br = bus.i_inst_branch;
         m_rd = bus.i_rd; m_rs = bus.i_res_src;
         m_pcn = bus.i_pc_next; m_pct = bus.i_pc_target;
         m_cnt = (M_EN && is_div(bus.i_alu_op) && !no_iter(bus.i_alu_op, bus.i_op1, bus.i_op2)) ? 32 : 0;
      end else if (m_cnt > 0) begin
         m_cnt = m_cnt - 1;
      end
   end

   // Compare process
   always @(negedge clk) begin
      if (m_live) begin
         chk("busy",       32'(bus.o_busy),      32'(m_cnt > 0));
         chk("reg_write",  32'(bus.o_reg_write), 32'(m_rw));
         chk("rd",         32'(bus.o_rd),        32'(m_rd));
         chk("store",      32'(bus.o_store),     32'(m_store));
         chk("store_data", bus.o_store_data,     m_sd);
         chk("funct3",     32'(bus.o_funct3),    32'(m_f3));
         chk("res_src",    32'(bus.o_res_src),   32'(m_rs));
         chk("pc_next",    {1'b0, bus.o_pc_next},   {1'b0, m_pcn});
         chk("pc_target",  {1'b0, bus.o_pc_target}, {1'b0, m_pct});
         chk("pc_select",  32'(bus.o_pc_select),
             32'(m_jj | (m_br & model_cond(m_f3, m_op1, m_op2))));
         if (!(is_div(m_aluop) && m_cnt > 0))
            chk("result", bus.o_result, model_res(m_aluop, m_op1, m_op2));
      end
   end

   // ------------------------------------------------------------------------
   // Directed stimulus
   // ------------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.i_alu_op = op;
      bus.i_op1    = a;
      bus.i_op2    = b;
   endtask

   task automatic nop();
      alu(4'd0, 32'd0, 32'd0);
      bus.i_reg_write = 1'b0;
   endtask

   // Issue one divide-class op, park a NOP behind it, return busy cycle count.
   task automatic run_div(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cycles);
      alu(op, a, b);
      bus.i_reg_write = 1'b1;
      tick();
      nop();
      cycles = 0;
      while (bus.o_busy && cycles < 40) begin
         cycles++;
         tick();
      end
   endtask

   int cyc;

   initial begin
      bus.i_flush = 1'b0; bus.i_stall = 1'b0;
      bus.i_op1 = '0; bus.i_op2 = '0; bus.i_alu_op = '0; bus.i_funct3 = '0;
      bus.i_reg_write = 1'b0; bus.i_rd = '0; bus.i_store = 1'b0;
      bus.i_inst_jal_jalr = 1'b0; bus.i_inst_branch = 1'b0; bus.i_res_src = '0;
      bus.i_pc_next = '0; bus.i_pc_target = '0; bus.i_reg_data2 = '0;

      tick(); tick();
      chk("reset_result", bus.o_result, 32'd0);
      chk("reset_busy",   32'(bus.o_busy), 32'd0);
      rst = 1'b0;

      // Arithmetic / logic
      alu(4'd0, 32'h7FFF_FFFF, 32'd1);
      bus.i_reg_write = 1'b1; bus.i_rd = 5'd5;
      bus.i_store = 1'b1; bus.i_reg_data2 = 32'hDEAD_BEEF;
      bus.i_res_src = 2'd2; bus.i_pc_next = 31'h0000_1004;
      tick();
      chk("add_wrap",   bus.o_result, 32'h8000_0000);
      chk("add_rd",     32'(bus.o_rd), 32'd5);
      chk("store_data", bus.o_store_data, 32'hDEAD_BEEF);
      bus.i_store = 1'b0; bus.i_res_src = 2'd0;

      alu(4'd7, 32'h8000_0000, 32'd4);          tick(); chk("sra",  bus.o_result, 32'hF800_0000);
      alu(4'd4, 32'd1, 32'hFFFF_FFFF);          tick(); chk("sltu", bus.o_result, 32'd1);
      alu(4'd3, 32'd1, 32'hFFFF_FFFF);          tick(); chk("slt",  bus.o_result, 32'd0);
      alu(4'd2, 32'd1, 32'h0000_003F);          tick(); chk("sll",  bus.o_result, 32'h8000_0000);
      alu(4'd1, 32'd0, 32'd1);                  tick(); chk("sub",  bus.o_result, 32'hFFFF_FFFF);
      alu(4'd6, 32'h8000_0000, 32'd31);         tick(); chk("srl",  bus.o_result, 32'd1);
      alu(4'd10, 32'd7, 32'h1234_5678);         tick(); chk("pass", bus.o_result, 32'h1234_5678);
      alu(4'd15, 32'd7, 32'd9);                 tick(); chk("rsvd", bus.o_result, 32'd0);

      // Branches
      alu(4'd0, 32'hFFFF_FFFF, 32'd0);
      bus.i_inst_branch = 1'b1; bus.i_funct3 = 3'b100; bus.i_pc_target = 31'h0012_3456;
      tick();
      chk("blt_sel", 32'(bus.o_pc_select), 32'd1);
      chk("blt_tgt", {1'b0, bus.o_pc_target}, 32'h0012_3456);
      bus.i_funct3 = 3'b110; tick(); chk("bltu_sel", 32'(bus.o_pc_select), 32'd0);
      bus.i_funct3 = 3'b010; tick(); chk("b010_sel", 32'(bus.o_pc_select), 32'd0);
      bus.i_inst_branch = 1'b0; bus.i_funct3 = 3'b000;
      bus.i_inst_jal_jalr = 1'b1; tick(); chk("jal_sel", 32'(bus.o_pc_select), 32'd1);
      bus.i_inst_jal_jalr = 1'b0;

      // Stall holds the stage
      alu(4'd5, 32'h0000_F0F0, 32'h0000_0FF0); tick(); chk("xor", bus.o_result, 32'h0000_FF00);
      bus.i_stall = 1'b1; alu(4'd8, 32'd1, 32'd2); tick(); tick();
      chk("stall_hold", bus.o_result, 32'h0000_FF00);
      bus.i_stall = 1'b0; tick(); chk("or", bus.o_result, 32'd3);

      // Divider
      run_div(4'd11, 32'hFFFF_FFF9, 32'd2, cyc);
      chk("div_busy_cycles", 32'(cyc), M_EN ? 32'd32 : 32'd0);
      chk("div_q", bus.o_result, M_EN ? 32'hFFFF_FFFD : 32'd0);
      bus.i_stall = 1'b1; tick(); tick();
      chk("div_stall_hold", bus.o_result, M_EN ? 32'hFFFF_FFFD : 32'd0);
      bus.i_stall = 1'b0; tick();

      run_div(4'd13, 32'hFFFF_FFF9, 32'd2, cyc);
      chk("rem_r", bus.o_result, M_EN ? 32'hFFFF_FFFF : 32'd0);
      run_div(4'd12, 32'd5, 32'd0, cyc);
      chk("divu_dz_cycles", 32'(cyc), 32'd0);
      chk("divu_dz", bus.o_result, M_EN ? 32'hFFFF_FFFF : 32'd0);
      tick();
      run_div(4'd13, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
      chk("rem_ovf_cycles", 32'(cyc), 32'd0);
      chk("rem_ovf", bus.o_result, 32'd0);
      tick();
      run_div(4'd12, 32'd100, 32'd7, cyc); chk("divu", bus.o_result, M_EN ? 32'd14 : 32'd0);
      tick();
      run_div(4'd14, 32'd100, 32'd7, cyc); chk("remu", bus.o_result, M_EN ? 32'd2 : 32'd0);
      tick();

      // Flush on cycle 10 of a running divide
      alu(4'd12, 32'd1000, 32'd3); bus.i_reg_write = 1'b1;
      tick();
      alu(4'd0, 32'd0, 32'd0);
      repeat (9) tick();
      bus.i_flush = 1'b1; tick(); bus.i_flush = 1'b0;
      chk("flush_busy", 32'(bus.o_busy), 32'd0);
      chk("flush_rw",   32'(bus.o_reg_write), 32'd0);
      alu(4'd0, 32'd2, 32'd3); bus.i_reg_write = 1'b1; tick();
      chk("add_after_flush", bus.o_result, 32'd5);

      // Reset mid-divide
      alu(4'd11, 32'd100, 32'd7); tick(); nop();
      repeat (4) tick();
      rst = 1'b1; tick(); rst = 1'b0;
      chk("rst_div_busy", 32'(bus.o_busy), 32'd0);

      // Reset with a taken branch and a pending write
      alu(4'd0, 32'd5, 32'd5);
      bus.i_inst_branch = 1'b1; bus.i_funct3 = 3'b000;
      bus.i_reg_write = 1'b1; bus.i_rd = 5'd9; bus.i_pc_target = 31'h0000_0ABC;
      tick();
      chk("beq_sel", 32'(bus.o_pc_select), 32'd1);
      rst = 1'b1; tick(); rst = 1'b0;
      bus.i_inst_branch = 1'b0; bus.i_reg_write = 1'b0; bus.i_rd = '0;
      chk("rst_sel",    32'(bus.o_pc_select), 32'd0);
      chk("rst_rw",     32'(bus.o_reg_write), 32'd0);
      chk("rst_rd",     32'(bus.o_rd), 32'd0);
      chk("rst_tgt",    {1'b0, bus.o_pc_target}, 32'd0);
      chk("rst_result", bus.o_result, 32'd0);

      tick(); tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire

// File: doc/rv_alu2.md
Name: rv_alu2

Overview:
- Execute stage directly downstream of the operand-select/PC-target stage.
- Registers that stage's outputs, computes the integer ALU result and resolves branches/jumps.
- Drives the redirect request (o_pc_select/o_pc_target) to fetch, and forwards store/writeback control to the memory stage.
- Optional iterative divider that stalls the pipeline through o_busy.

Parameters:
IADDR_SPACE_BITS, 32, instruction address width; PC ports are [IADDR_SPACE_BITS-1:1]

Ports:
i_clk  in  1  clock; all state on rising edge
i_reset  in  1  synchronous, active-high reset
i_flush  in  1  squash the instruction in this stage
i_stall  in  1  downstream stall; hold stage register
i_op1  in  32  ALU operand 1
i_op2  in  32  ALU operand 2
i_alu_op  in  4  operation code (encoding below)
i_funct3  in  3  branch condition / memory size
i_reg_write  in  1  writes rd
i_rd  in  5  destination register
i_store  in  1  store instruction
i_inst_jal_jalr  in  1  unconditional jump (incl. mret)
i_inst_branch  in  1  conditional branch
i_res_src  in  2  writeback select: 0 ALU, 1 memory, 2 pc_next
i_pc_next  in  IADDR_SPACE_BITS-1  link address
i_pc_target  in  IADDR_SPACE_BITS-1  jump/branch target
i_reg_data2  in  32  store data
o_result  out  32  ALU result
o_reg_write  out  1  registered reg_write
o_rd  out  5  registered rd
o_store  out  1  registered store
o_store_data  out  32  registered reg_data2
o_funct3  out  3  registered funct3
o_res_src  out  2  registered res_src
o_pc_next  out  IADDR_SPACE_BITS-1  registered pc_next
o_pc_select  out  1  redirect fetch to o_pc_target
o_pc_target  out  IADDR_SPACE_BITS-1  registered target
o_busy  out  1  stage occupied by an unfinished divide

Behaviour:
Stage register priority:
- i_reset: all stage registers and outputs go to 0, divider FSM to IDLE.
- Else i_flush: clear reg_write, store, jal_jalr, branch, res_src, alu_op (ADD); divider FSM to IDLE.
- Else if !i_stall && !o_busy: load all inputs.
- Otherwise hold.

Result and redirect timing:
- o_result is combinational from the stage registers, so it is valid the cycle after capture.
- o_pc_select = jal_jalr | (branch & cond).
- o_busy never asserted while jal_jalr or branch is held.

alu_op encoding:
- 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS op2.
- 11 DIV, 12 DIVU, 13 REM, 14 REMU, 15 reserved -> result 0.
- Shift amount is op2[4:0]; ADD/SUB wrap modulo 2^32.
- SLT/SLTU produce 32'd0 or 32'd1.

Branch cond (funct3), compared on op1/op2:
- 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU.
- 010/011 -> cond 0.

Divider FSM (macro enabled), states IDLE, RUN, DONE:
- Capture of a div op: special case -> DONE, else -> RUN with count 31.
- RUN: one restoring step on magnitudes per cycle. At count 0 -> DONE, applying sign correction (quotient sign = op1^op2 for signed; remainder sign = op1).
- DONE: result held until the stage register loads again, then -> IDLE, or to RUN/DONE if the new op is a div.
- o_busy = div op held && state != DONE. A normal divide is busy for exactly 32 cycles; the result appears in cycle 33 after capture.
- Divide by zero: quotient 0xFFFFFFFF, remainder = op1, no iteration.
- Signed overflow 0x80000000 / -1: quotient 0x80000000, remainder 0, no iteration.

Boundary and priority cases:
- Flush during RUN aborts the divide; o_busy is 0 the next cycle.
- Reset mid-divide behaves the same as flush.
- i_stall while DONE holds the result.
- i_stall has no effect on RUN progress.

Optional Feature:
RV_EXT_M_EN
- Defined: divider and FSM present as described above.
- Undefined: no divider logic; alu_op 11-14 give result 0; o_busy tied 0.

Test Plan:
- ADD 0x7FFFFFFF + 1 -> o_result 0x80000000. SRA 0x80000000 by 4 -> 0xF8000000. SLTU 1 vs 0xFFFFFFFF -> 1.
- Branch funct3=100, op1=-1, op2=0 -> o_pc_select=1, o_pc_target = captured target. funct3=110 with the same operands -> 0.
- DIV -7/2 (macro on) -> o_busy high 32 cycles, then quotient 0xFFFFFFFD. REM -7/2 -> remainder 0xFFFFFFFF.
- DIVU 5/0 -> o_busy never high, quotient 0xFFFFFFFF. REM 0x80000000 / -1 -> 0 immediately.
- Flush asserted on cycle 10 of RUN -> o_busy 0 next cycle, o_reg_write 0. Next ADD is captured normally.
- Reset asserted with a pending branch and reg_write -> next cycle all outputs 0, o_pc_select 0, o_busy 0.
